// File: rtl/coord_pkg.sv
// Shared definitions for the coordinate quantizer: packed field indices,
// coordinate counts and the round-half-up helper used by every coordinate lane.
package coord_pkg;

    // Field positions inside the packed bbox word {max_y,max_x,min_y,min_x}.
    localparam int MIN_X = 0;
    localparam int MIN_Y = 1;
    localparam int MAX_X = 2;
    localparam int MAX_Y = 3;

    // Field positions inside the packed vertex word {y2,x2,y1,x1,y0,x0}.
    localparam int X0 = 0;
    localparam int Y0 = 1;
    localparam int X1 = 2;
    localparam int Y1 = 3;
    localparam int X2 = 4;
    localparam int Y2 = 5;

    localparam int NUM_BBOX  = 4;
    localparam int NUM_VTX   = 6;
    localparam int NUM_COORD = NUM_BBOX + NUM_VTX;

    // Working width of the rounding helper; inputs up to 63 bits fit with headroom.
    localparam int ROUND_MAX_W = 64;

    localparam int CULL_CNT_W = 16;

    // Round-half-up of a signed fixed-point value to an integer. The sum is
    // formed at the wide working width, so adding the half LSB never wraps
    // even for the most positive input.
    function automatic logic signed [ROUND_MAX_W-1:0] round_half_up(
        input logic signed [ROUND_MAX_W-1:0] value,
        input int                            frac_w
    );
        logic signed [ROUND_MAX_W-1:0] half;
        half = ROUND_MAX_W'(64'sd1 <<< (frac_w - 1));
        return (value + half) >>> frac_w;
    endfunction

    // Clamp limit for a field index. In both packed words x fields sit at
    // even positions and y fields at odd positions.
    function automatic int coord_limit(
        input int index,
        input int screen_w,
        input int screen_h
    );
        return ((index % 2) == 0) ? (screen_w - 1) : (screen_h - 1);
    endfunction

endpackage

// File: rtl/coord_round_clamp.sv
// One coordinate lane of the quantizer: stage 1 registers the rounded integer,
// stage 2 registers the value clamped to [0, LIMIT] and whether clamping hit.
// The parent owns the handshake and supplies the two stage enables.
module coord_round_clamp
    import coord_pkg::*;
#(
    parameter int INPUT_W  = 32,
    parameter int FRAC_W   = 4,
    parameter int OUTPUT_W = 10,
    parameter int LIMIT    = 639
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s1_en,
    input  logic                s2_en,
    input  logic [INPUT_W-1:0]  coord,
    output logic                below,
    output logic                above,
    output logic [OUTPUT_W-1:0] value,
    output logic                clamped
);

    // One sign bit of headroom over the integer part of the input.
    localparam int RND_W = INPUT_W + 1 - FRAC_W;

    logic signed [RND_W-1:0] rnd;
    logic [OUTPUT_W-1:0]     clamp_value;

    // Stage 1: capture the rounded integer of the incoming coordinate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd <= '0;
        end else if (s1_en) begin
            rnd <= RND_W'(round_half_up(ROUND_MAX_W'($signed(coord)), FRAC_W));
        end
    end

    // Classify the stage-1 value against the screen edge and pick the clamped result.
    always_comb begin
        below       = rnd[RND_W-1];
        above       = !below && (ROUND_MAX_W'(rnd) > ROUND_MAX_W'(LIMIT));
        clamp_value = OUTPUT_W'(rnd);
        if (below) begin
            clamp_value = '0;
        end else if (above) begin
            clamp_value = OUTPUT_W'(LIMIT);
        end
    end

    // Stage 2: hold the clamped pixel coordinate and its clamp flag for the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value   <= '0;
            clamped <= 1'b0;
        end else if (s2_en) begin
            value   <= clamp_value;
            clamped <= below || above;
        end
    end

endmodule

// File: rtl/coord_quantizer.sv
// Coordinate quantizer: rounds signed fixed-point triangle data (bbox plus three
// vertices) to integer pixels and clamps it to the screen, through a 2-stage
// valid/ready pipeline. Optional macro COORD_QUANTIZER_CULL_EN drops triangles
// whose rounded bbox lies fully off-screen and exposes a saturating cull_count.
module coord_quantizer
    import coord_pkg::*;
#(
    parameter int INPUT_W  = 32,
    parameter int FRAC_W   = 4,
    parameter int OUTPUT_W = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_BBOX*INPUT_W-1:0]     in_bbox,
    input  logic [NUM_VTX*INPUT_W-1:0]      in_vtx,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_BBOX*OUTPUT_W-1:0]    out_bbox,
    output logic [NUM_VTX*OUTPUT_W-1:0]     out_vtx,
`ifdef COORD_QUANTIZER_CULL_EN
    output logic [CULL_CNT_W-1:0]           cull_count,
`endif
    output logic                            out_clamped
);

    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;
    logic s1_en;
    logic s2_en;
    logic cull;

    // Lane flags: indices 0..3 are bbox fields, 4..9 are vertex fields.
    logic [NUM_COORD-1:0] below;
    logic [NUM_COORD-1:0] above;
    logic [NUM_COORD-1:0] clamped;

    // Only the bbox flags feed the cull decision; the rest are deliberately left
    // unconsumed and collected here.
    logic unused_flags;
    assign unused_flags = ^{below, above};

    // Handshake: a stage may move when its successor is empty or moving.
    always_comb begin
        s2_adv = !s2_valid || out_ready;
        s1_adv = !s1_valid || s2_adv;
        s1_en  = s1_adv && in_valid;
        s2_en  = s2_adv && s1_valid && !cull;
    end

    assign in_ready    = s1_adv;
    assign out_valid   = s2_valid;
    assign out_clamped = |clamped;

    // Valid bits follow the data; a culled triangle leaves stage 2 empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid && !cull;
            end
        end
    end

`ifdef COORD_QUANTIZER_CULL_EN
    // A triangle is culled when its rounded bbox misses the screen on any side.
    always_comb begin
        cull = s1_valid && (below[MAX_X] || above[MIN_X] ||
                            below[MAX_Y] || above[MIN_Y]);
    end

    // Count culled triangles as they leave stage 1, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cull_count <= '0;
        end else if (s2_adv && cull && (cull_count != '1)) begin
            cull_count <= cull_count + CULL_CNT_W'(1);
        end
    end
`else
    assign cull = 1'b0;
`endif

    // Bbox lanes: x fields clamp against the screen width, y fields against the height.
    for (genvar i = 0; i < NUM_BBOX; i++) begin : g_bbox
        coord_round_clamp #(
            .INPUT_W  (INPUT_W),
            .FRAC_W   (FRAC_W),
            .OUTPUT_W (OUTPUT_W),
            .LIMIT    (coord_limit(i, SCREEN_W, SCREEN_H))
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .s1_en   (s1_en),
            .s2_en   (s2_en),
            .coord   (in_bbox[i*INPUT_W +: INPUT_W]),
            .below   (below[i]),
            .above   (above[i]),
            .value   (out_bbox[i*OUTPUT_W +: OUTPUT_W]),
            .clamped (clamped[i])
        );
    end

    // Vertex lanes, same alternating x/y layout as the bbox word.
    for (genvar i = 0; i < NUM_VTX; i++) begin : g_vtx
        coord_round_clamp #(
            .INPUT_W  (INPUT_W),
            .FRAC_W   (FRAC_W),
            .OUTPUT_W (OUTPUT_W),
            .LIMIT    (coord_limit(i, SCREEN_W, SCREEN_H))
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .s1_en   (s1_en),
            .s2_en   (s2_en),
            .coord   (in_vtx[i*INPUT_W +: INPUT_W]),
            .below   (below[NUM_BBOX+i]),
            .above   (above[NUM_BBOX+i]),
            .value   (out_vtx[i*OUTPUT_W +: OUTPUT_W]),
            .clamped (clamped[NUM_BBOX+i])
        );
    end

endmodule

// File: tb/tb_coord_quantizer.sv
// Self-checking bench for coord_quantizer: directed steps for rounding, clamping,
// backpressure, throughput and mid-stream reset, then randomized traffic checked
// against an arithmetic reference model and an in-order scoreboard.
// The cull steps are compiled only when COORD_QUANTIZER_CULL_EN is defined.
module tb_coord_quantizer;

    localparam int INPUT_W  = 32;
    localparam int FRAC_W   = 4;
    localparam int OUTPUT_W = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct {
        logic [4*OUTPUT_W-1:0] bbox;
        logic [6*OUTPUT_W-1:0] vtx;
        logic                  clamped;
    } tri_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [4*INPUT_W-1:0]    in_bbox = '0;
    logic [6*INPUT_W-1:0]    in_vtx = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [4*OUTPUT_W-1:0]   out_bbox;
    logic [6*OUTPUT_W-1:0]   out_vtx;
    logic                    out_clamped;
`ifdef COORD_QUANTIZER_CULL_EN
    logic [15:0]             cull_count;
`endif

    int   compareCount = 0;
    int   failCount    = 0;
    int   outCount     = 0;
    int   expCull      = 0;
    bit   lastAccept;
    bit   lastInReady;
    bit   lastOutValid;
    tri_t expQ[$];

    coord_quantizer #(
        .INPUT_W  (INPUT_W),
        .FRAC_W   (FRAC_W),
        .OUTPUT_W (OUTPUT_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bbox     (in_bbox),
        .in_vtx      (in_vtx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bbox    (out_bbox),
        .out_vtx     (out_vtx),
`ifdef COORD_QUANTIZER_CULL_EN
        .cull_count  (cull_count),
`endif
        .out_clamped (out_clamped)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the design wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Round-half-up by plain integer arithmetic: floor((v + half) / scale).
    function automatic longint roundRef(input logic [INPUT_W-1:0] raw);
        longint scale;
        longint shifted;
        longint q;
        scale   = longint'(1) << FRAC_W;
        shifted = longint'($signed(raw)) + scale / 2;
        q       = shifted / scale;
        if ((shifted % scale) != 0 && shifted < 0) q = q - 1;
        return q;
    endfunction

    // Expected output triangle and cull decision for one input triangle.
    function automatic void modelTri(input logic [4*INPUT_W-1:0] b, input logic [6*INPUT_W-1:0] v,
                                     output tri_t t, output bit culled);
        longint r[10];
        longint lim;
        longint c;
        t.bbox = '0;
        t.vtx = '0;
        t.clamped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            lim = ((i % 2) == 0) ? SCREEN_W - 1 : SCREEN_H - 1;
            if (i < 4) r[i] = roundRef(b[i*INPUT_W +: INPUT_W]);
            else       r[i] = roundRef(v[(i-4)*INPUT_W +: INPUT_W]);
            if (r[i] < 0) begin
                c = 0;
                t.clamped = 1'b1;
            end else if (r[i] > lim) begin
                c = lim;
                t.clamped = 1'b1;
            end else begin
                c = r[i];
            end
            if (i < 4) t.bbox[i*OUTPUT_W +: OUTPUT_W] = OUTPUT_W'(c);
            else       t.vtx[(i-4)*OUTPUT_W +: OUTPUT_W] = OUTPUT_W'(c);
        end
        culled = (r[2] < 0) || (r[0] > SCREEN_W - 1) || (r[3] < 0) || (r[1] > SCREEN_H - 1);
    endfunction

    function automatic logic [4*INPUT_W-1:0] mkBbox(input logic [INPUT_W-1:0] min_x, input logic [INPUT_W-1:0] min_y,
                                                    input logic [INPUT_W-1:0] max_x, input logic [INPUT_W-1:0] max_y);
        return {max_y, max_x, min_y, min_x};
    endfunction

    function automatic logic [6*INPUT_W-1:0] mkVtx(input logic [INPUT_W-1:0] x0, input logic [INPUT_W-1:0] y0,
                                                   input logic [INPUT_W-1:0] x1, input logic [INPUT_W-1:0] y1,
                                                   input logic [INPUT_W-1:0] x2, input logic [INPUT_W-1:0] y2);
        return {y2, x2, y1, x1, y0, x0};
    endfunction

    // Random coordinate: mostly near the screen, with halves, raw noise and extremes.
    function automatic logic [INPUT_W-1:0] randCoord(input int lim);
        int mode;
        int p;
        mode = int'($urandom_range(0, 6));
        case (mode)
            0: return INPUT_W'($urandom);
            1: begin
                case ($urandom_range(0, 3))
                    0: return 32'h8000_0000;
                    1: return 32'h7FFF_FFFF;
                    2: return 32'h7FFF_FFF8;
                    default: return 32'hFFFF_FFF8;
                endcase
            end
            2: begin
                p = int'($urandom_range(0, lim + 40)) - 20;
                return INPUT_W'(p * 16 + (($urandom_range(0, 1) == 0) ? 8 : -8));
            end
            default: begin
                p = int'($urandom_range(0, lim + 64)) - 32;
                return INPUT_W'(p * 16 + int'($urandom_range(0, 15)));
            end
        endcase
    endfunction

    task automatic randTri(output logic [4*INPUT_W-1:0] b, output logic [6*INPUT_W-1:0] v);
        for (int i = 0; i < 4; i++) b[i*INPUT_W +: INPUT_W] = randCoord(((i % 2) == 0) ? SCREEN_W - 1 : SCREEN_H - 1);
        for (int i = 0; i < 6; i++) v[i*INPUT_W +: INPUT_W] = randCoord(((i % 2) == 0) ? SCREEN_W - 1 : SCREEN_H - 1);
    endtask

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, sample the handshake at the falling edge, score the output
    // side against the queue head (also while stalled), record accepted inputs.
    task automatic applyStimulus(input logic v, input logic [4*INPUT_W-1:0] b,
                                 input logic [6*INPUT_W-1:0] x, input logic rdy);
        tri_t t;
        bit   culled;
        in_valid  = v;
        in_bbox   = b;
        in_vtx    = x;
        out_ready = rdy;
        @(negedge clk);
        lastInReady  = in_ready;
        lastOutValid = out_valid;
        lastAccept   = in_valid && in_ready;
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
                checkOutput("out_bbox", 64'(out_bbox), 64'(expQ[0].bbox));
                checkOutput("out_vtx", 64'(out_vtx), 64'(expQ[0].vtx));
                checkOutput("out_clamped", 64'(out_clamped), 64'(expQ[0].clamped));
                if (out_ready) begin
                    void'(expQ.pop_front());
                    outCount++;
                end
            end
        end
        if (lastAccept) begin
            modelTri(b, x, t, culled);
`ifdef COORD_QUANTIZER_CULL_EN
            if (culled) begin
                if (expCull < 65535) expCull++;
            end else begin
                expQ.push_back(t);
            end
`else
            expQ.push_back(t);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    // Let the pipeline empty with bounded idle cycles, then confirm nothing is left.
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 40) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            guard++;
        end
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput(tag, 64'(expQ.size()), 64'(0));
    endtask

    logic [4*INPUT_W-1:0] tb_b;
    logic [6*INPUT_W-1:0] tb_v;
    logic [4*INPUT_W-1:0] bpB[5];
    logic [6*INPUT_W-1:0] bpV[5];

    initial begin
        int sent;
        int guard;
        int outBase;

        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_out_bbox", 64'(out_bbox), 64'(0));
        checkOutput("reset_out_vtx", 64'(out_vtx), 64'(0));
        checkOutput("reset_out_clamped", 64'(out_clamped), 64'(0));
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
`ifdef COORD_QUANTIZER_CULL_EN
        checkOutput("reset_cull_count", 64'(cull_count), 64'(0));
`endif

        // Rounding: x0 = 50.5 goes up to 51, y0 = ~50.44 goes down to 50.
        tb_b = mkBbox(32'h320, 32'h320, 32'h640, 32'h640);
        tb_v = mkVtx(32'h328, 32'h327, 32'h400, 32'h400, 32'h600, 32'h500);
        applyStimulus(1'b1, tb_b, tb_v, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("round_lat_cycle1", 64'(lastOutValid), 64'(0));
        checkOutput("round_x0", 64'(out_vtx[9:0]), 64'(51));
        checkOutput("round_y0", 64'(out_vtx[19:10]), 64'(50));
        checkOutput("round_clamped", 64'(out_clamped), 64'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("round_lat_cycle2", 64'(lastOutValid), 64'(1));
        drain("round_drain");

        // Clamping: -3.5 rounds to -3 then clamps to 0; 700 and 480 clamp to the edges.
        tb_b = mkBbox(32'h0, 32'h0, 32'h1000, 32'h1000);
        tb_v = mkVtx(32'h100, 32'h100, 32'hFFFF_FFC8, 32'h200, 32'h2BC0, 32'h1E00);
        applyStimulus(1'b1, tb_b, tb_v, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("clamp_x1_neg", 64'(out_vtx[29:20]), 64'(0));
        checkOutput("clamp_x2_high", 64'(out_vtx[49:40]), 64'(639));
        checkOutput("clamp_y2_high", 64'(out_vtx[59:50]), 64'(479));
        checkOutput("clamp_flag", 64'(out_clamped), 64'(1));
        drain("clamp_drain");

        // Backpressure: downstream blocked for 4 cycles while 5 triangles are offered.
        for (int i = 0; i < 5; i++) begin
            bpB[i] = mkBbox(INPUT_W'(16 * (10 + i)), INPUT_W'(16 * (20 + i)), INPUT_W'(16 * (300 + i)), INPUT_W'(16 * (200 + i)));
            bpV[i] = mkVtx(INPUT_W'(16 * (11 + i) + 8), INPUT_W'(16 * (21 + i) + 7), INPUT_W'(16 * (100 + i)),
                           INPUT_W'(16 * (50 + i)), INPUT_W'(16 * (290 + i)), INPUT_W'(16 * (190 + i)));
        end
        sent = 0;
        outBase = outCount;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, bpB[sent], bpV[sent], 1'b0);
            checkOutput("bp_in_ready", 64'(lastInReady), (k < 2) ? 64'(1) : 64'(0));
            if (lastAccept) sent++;
        end
        guard = 0;
        while (sent < 5 && guard < 50) begin
            applyStimulus(1'b1, bpB[sent], bpV[sent], 1'b1);
            if (lastAccept) sent++;
            guard++;
        end
        checkOutput("bp_all_sent", 64'(sent), 64'(5));
        drain("bp_drain");
        checkOutput("bp_emitted", 64'(outCount - outBase), 64'(5));

        // Full throughput: 8 back-to-back triangles, output valid in cycles 2..9.
        outBase = outCount;
        for (int k = 0; k < 12; k++) begin
            randTri(tb_b, tb_v);
            tb_b = mkBbox(INPUT_W'(16 * k), INPUT_W'(16 * k), INPUT_W'(16 * (600 - k)), INPUT_W'(16 * (400 - k)));
            applyStimulus((k < 8) ? 1'b1 : 1'b0, tb_b, tb_v, 1'b1);
            if (k < 8) checkOutput("tp_in_ready", 64'(lastInReady), 64'(1));
            checkOutput("tp_out_valid", 64'(lastOutValid), (k >= 2 && k <= 9) ? 64'(1) : 64'(0));
        end
        drain("tp_drain");
        checkOutput("tp_emitted", 64'(outCount - outBase), 64'(8));

        // Reset with two triangles in flight: outputs clear at once, without a clock edge.
        tb_b = mkBbox(32'h100, 32'h100, 32'h800, 32'h800);
        tb_v = mkVtx(32'h150, 32'h160, 32'h170, 32'h180, 32'h190, 32'h1A0);
        applyStimulus(1'b1, tb_b, tb_v, 1'b1);
        applyStimulus(1'b1, tb_b, tb_v, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("midrst_out_bbox", 64'(out_bbox), 64'(0));
        checkOutput("midrst_out_vtx", 64'(out_vtx), 64'(0));
        checkOutput("midrst_out_clamped", 64'(out_clamped), 64'(0));
        in_valid = 1'b0;
        expQ.delete();
        expCull = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));
        tb_v = mkVtx(32'h328, 32'h327, 32'h400, 32'h400, 32'h600, 32'h500);
        applyStimulus(1'b1, tb_b, tb_v, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("midrst_lat_cycle1", 64'(lastOutValid), 64'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("midrst_lat_cycle2", 64'(lastOutValid), 64'(1));
        drain("midrst_drain");

`ifdef COORD_QUANTIZER_CULL_EN
        // Cull: a bbox from x=650 to x=700 is entirely right of the screen.
        outBase = outCount;
        tb_b = mkBbox(32'h28A0, 32'h100, 32'h2BC0, 32'h200);
        applyStimulus(1'b1, tb_b, tb_v, 1'b1);
        tb_b = mkBbox(32'h100, 32'h100, 32'h800, 32'h800);
        applyStimulus(1'b1, tb_b, tb_v, 1'b1);
        drain("cull_drain");
        checkOutput("cull_count_one", 64'(cull_count), 64'(1));
        checkOutput("cull_emitted", 64'(outCount - outBase), 64'(1));
`endif

        // Randomized traffic with random backpressure against the reference model.
        for (int k = 0; k < 400; k++) begin
            randTri(tb_b, tb_v);
            applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, tb_b, tb_v,
                          ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end
        drain("rand_drain");
`ifdef COORD_QUANTIZER_CULL_EN
        checkOutput("rand_cull_count", 64'(cull_count), 64'(expCull));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
